// File: rtl/data_mem_resp.sv
// Data-side memory responder: word RAM with byte-lane writes, whole-word reads
// returned after LAT cycles, and a stall toward the pipeline while busy.
module data_mem_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        stall
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                ram_we;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         ram [Depth];

  // High index bits and byte offset are discarded, so addresses alias.
  assign idx = addr[ADDR_W+1:2];
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Next-state, RAM write strobe and the combinational stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    ram_we  = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          stall = 1'b1;
          if (wen != 4'b0000) begin
            // Gate with rst so nothing commits while reset is held.
            ram_we  = ~rst;
            state_d = StResp;
            ack_d   = 1'b1;
          end else if (LAT == 1) begin
            rdata_d = ram[idx];
            state_d = StResp;
            ack_d   = 1'b1;
          end else begin
            idx_d   = idx;
            cnt_d   = 3'(LAT - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = ram[idx_q];
          state_d = StResp;
          ack_d   = 1'b1;
        end
      end
      // req still belongs to the completing access; ignore it here.
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control and output registers; in-flight reads are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (LAT = 1, 3, 4) driven with a
// vector table, hand-written corner sequences and randomized accesses
// checked against a word-array reference model.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_s   [3];
  logic        req_s   [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  wen_s   [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        ack_s   [3];
  logic        stall_s [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_resp #(
      .ADDR_W(10),
      .LAT   ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk  (clk),
      .rst  (rst_s[g]),
      .req  (req_s[g]),
      .addr (addr_s[g]),
      .wen  (wen_s[g]),
      .wdata(wdata_s[g]),
      .rdata(rdata_s[g]),
      .ack  (ack_s[g]),
      .stall(stall_s[g])
    );
  end

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] last_rd [3];
  logic [31:0] ref_mem [3][16];

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 3 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access: drive at negedge, sample 1 ns later each cycle.
  task automatic access(input int sel, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int stalls, output int ack_at);
    @(negedge clk);
    req_s[sel] = 1'b1; addr_s[sel] = a; wen_s[sel] = w; wdata_s[sel] = d;
    stalls = 0; ack_at = 0; rd = '0;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (stall_s[sel]) stalls++;
      if (ack_s[sel]) begin
        ack_at = n; rd = rdata_s[sel];
        req_s[sel] = 1'b0; wen_s[sel] = '0;
        break;
      end
      @(negedge clk);
    end
    if (ack_at == 0) begin
      n_cmp++; n_err++;
      $display("FAIL ack_timeout: inst %0d got no ack, required one within 20 cycles", sel);
      req_s[sel] = 1'b0;
    end
  endtask

  task automatic run(input string name, input int sel, input logic [31:0] a,
                     input logic [3:0] w, input logic [31:0] d, input logic [31:0] exp_rd);
    logic [31:0] rd;
    int stalls, ack_at, lat;
    access(sel, a, w, d, rd, stalls, ack_at);
    lat = (w != 4'b0000) ? 1 : lat_of(sel);
    check({name, "_stall"}, 32'(stalls), 32'(lat));
    check({name, "_ackcyc"}, 32'(ack_at), 32'(lat + 1));
    if (w == 4'b0000) begin
      check({name, "_rdata"}, rd, exp_rd);
      last_rd[sel] = exp_rd;
    end else begin
      check({name, "_rdhold"}, rd, last_rd[sel]);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] w,
                                        input logic [31:0] d);
    logic [31:0] m;
    m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  initial begin
    logic [31:0] a, d, rd;
    logic [3:0]  w;
    int          ix, acks;

    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; req_s[i] = 1'b0; addr_s[i] = '0; wen_s[i] = '0;
      wdata_s[i] = '0; last_rd[i] = '0;
    end

    vecs[0]  = '{0, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 32'h0000_0011, 4'h2, 32'h0000AA00, 32'h0};
    vecs[3]  = '{0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADAAEF};
    vecs[4]  = '{0, 32'h0000_0010, 4'hC, 32'h12340000, 32'h0};
    vecs[5]  = '{0, 32'h0000_0010, 4'h0, 32'h0,        32'h1234AAEF};
    vecs[6]  = '{0, 32'h0000_1000, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[7]  = '{0, 32'h0000_0003, 4'h0, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{1, 32'h0000_0020, 4'hF, 32'h55AA1234, 32'h0};
    vecs[9]  = '{1, 32'h0000_0020, 4'h0, 32'h0,        32'h55AA1234};
    vecs[10] = '{1, 32'h0000_0022, 4'h4, 32'h00770000, 32'h0};
    vecs[11] = '{1, 32'h0000_0020, 4'h0, 32'h0,        32'h55771234};
    vecs[12] = '{2, 32'h0000_0010, 4'hF, 32'h0BADF00D, 32'h0};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ack%0d", i), 32'(ack_s[i]), 32'h0);
      check($sformatf("rst_stall%0d", i), 32'(stall_s[i]), 32'h0);
      check($sformatf("rst_rdata%0d", i), rdata_s[i], 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

    for (int v = 0; v < 13; v++)
      run($sformatf("vec%0d", v), vecs[v].sel, vecs[v].addr, vecs[v].wen,
          vecs[v].wdata, vecs[v].exp);
    run("vec13", 2, 32'h0000_0010, 4'h0, 32'h0, 32'h0BADF00D);

    // req held across store then load to the same word (LAT=1).
    @(negedge clk);
    req_s[0] = 1'b1; addr_s[0] = 32'h40; wen_s[0] = 4'hF; wdata_s[0] = 32'h13579BDF;
    #1;
    check("hold_c1_stall", 32'(stall_s[0]), 32'h1);
    check("hold_c1_ack", 32'(ack_s[0]), 32'h0);
    @(negedge clk); #1;
    check("hold_c2_ack", 32'(ack_s[0]), 32'h1);
    check("hold_c2_stall", 32'(stall_s[0]), 32'h0);
    wen_s[0] = 4'h0;
    @(negedge clk); #1;
    check("hold_c3_stall", 32'(stall_s[0]), 32'h1);
    check("hold_c3_ack", 32'(ack_s[0]), 32'h0);
    @(negedge clk); #1;
    check("hold_c4_ack", 32'(ack_s[0]), 32'h1);
    check("hold_c4_rdata", rdata_s[0], 32'h13579BDF);
    req_s[0] = 1'b0;
    last_rd[0] = 32'h13579BDF;
    @(negedge clk); #1;
    check("hold_c5_ack", 32'(ack_s[0]), 32'h0);
    check("hold_c5_stall", 32'(stall_s[0]), 32'h0);

    // Reset during BUSY (LAT=4): read dropped, then serviced normally.
    @(negedge clk);
    req_s[2] = 1'b1; addr_s[2] = 32'h10; wen_s[2] = 4'h0;
    @(negedge clk); #1;
    check("rstmid_busy_stall", 32'(stall_s[2]), 32'h1);
    rst_s[2] = 1'b1; req_s[2] = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall_s[2]), 32'h0);
    check("rstmid_ack", 32'(ack_s[2]), 32'h0);
    check("rstmid_rdata", rdata_s[2], 32'h0);
    @(negedge clk);
    rst_s[2] = 1'b0;
    last_rd[2] = '0;
    acks = 0;
    for (int n = 0; n < 6; n++) begin
      #1; if (ack_s[2]) acks++;
      @(negedge clk);
    end
    check("rstmid_no_ack", 32'(acks), 32'h0);
    run("rstmid_reload", 2, 32'h0000_0010, 4'h0, 32'h0, 32'h0BADF00D);

    // Randomized accesses over 16 words with aliased upper address bits.
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 16; i++) begin
        d = $urandom();
        a = ($urandom() & 32'hFFFF_F000) | 32'(i << 2) | ($urandom() & 32'h3);
        ref_mem[s][i] = d;
        run("rnd_pre", s, a, 4'hF, d, 32'h0);
      end
      for (int k = 0; k < 60; k++) begin
        ix = int'($urandom_range(0, 15));
        a  = ($urandom() & 32'hFFFF_F000) | 32'(ix << 2) | ($urandom() & 32'h3);
        w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        d  = $urandom();
        if (w == 4'h0) begin
          run($sformatf("rnd%0d_%0d_rd", s, k), s, a, w, d, ref_mem[s][ix]);
        end else begin
          ref_mem[s][ix] = merge(ref_mem[s][ix], w, d);
          run($sformatf("rnd%0d_%0d_wr", s, k), s, a, w, d, 32'h0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
